// File: rtl/cpucr_bus_pkg.sv
// Shared definitions for the CPUCR memory bus master: FSM states,
// bus widths and LE strobe encodings.
package cpucr_bus_pkg;

  localparam int DIR_ANCHO  = 16;
  localparam int DATO_ANCHO = 8;

  // LE high means the memory may drive Datos; LE low is the write strobe.
  localparam logic LE_LEER     = 1'b1;
  localparam logic LE_ESCRIBIR = 1'b0;

  typedef enum logic [2:0] {
    REPOSO,
    LECT,
    ESCR_PREP,
    ESCR_PULSO,
    ESCR_FIN
  } estado_t;

endpackage

// File: rtl/contador_espera.sv
// Wait-state down-counter: loaded with a cycle count, decremented while
// the FSM waits, and flags cero when the count has run out.
module contador_espera #(
  parameter int ANCHO = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             cargar,
  input  logic [ANCHO-1:0] valor,
  input  logic             decrementar,
  output logic             cero
);

  logic [ANCHO-1:0] cuenta_reg;

  // Load has priority; decrementing saturates at zero.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cuenta_reg <= '0;
    end else if (cargar) begin
      cuenta_reg <= valor;
    end else if (decrementar && (cuenta_reg != '0)) begin
      cuenta_reg <= cuenta_reg - 1'b1;
    end
  end

  assign cero = (cuenta_reg == '0);

endmodule

// File: rtl/controlador_bus.sv
// CPU-side bus master for CPUCR main memory. Converts single-cycle CPU
// read/write requests into Direccion/Datos/LE bus cycles.
// Optional feature: define CARGA_EN to add the program-load port.
// LE and the Datos output enable are both decoded from the registered
// state, so the controller can never drive Datos while LE=1.
module controlador_bus
  import cpucr_bus_pkg::*;
#(
  parameter int T_LECT = 2,
  parameter int T_ESCR = 2
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Pet,
  input  logic                  Escribir,
  input  logic [DIR_ANCHO-1:0]  Pet_dir,
  input  logic [DATO_ANCHO-1:0] Pet_dato,
  output logic                  Listo,
  output logic [DATO_ANCHO-1:0] Dato_leido,
  output logic                  Ocupado,
  output logic [DIR_ANCHO-1:0]  Direccion,
  inout  wire  [DATO_ANCHO-1:0] Datos,
  output logic                  LE
`ifdef CARGA_EN
  ,
  input  logic                  Carga_activa,
  input  logic                  Carga_valido,
  input  logic [DATO_ANCHO-1:0] Carga_dato,
  output logic                  Carga_listo,
  input  logic [DIR_ANCHO-1:0]  Carga_base
`endif
);

  // Counter is loaded with N-1 so that the wait lasts exactly N cycles.
  localparam logic [7:0] CUENTA_LECT = 8'(T_LECT - 1);
  localparam logic [7:0] CUENTA_ESCR = 8'(T_ESCR - 1);

  estado_t                 estado_reg, estado_next;
  logic [DIR_ANCHO-1:0]    dir_reg;
  logic [DATO_ANCHO-1:0]   dato_reg;
  logic [DATO_ANCHO-1:0]   leido_reg;
  logic                    listo_reg;

  logic                    aceptar;
  logic                    es_escritura;
  logic [DIR_ANCHO-1:0]    dir_in;
  logic [DATO_ANCHO-1:0]   dato_in;

  logic                    cnt_cargar;
  logic                    cnt_dec;
  logic [7:0]              cnt_valor;
  logic                    cnt_cero;
  logic                    datos_oe;

`ifdef CARGA_EN
  logic                    activa_prev_reg;
  logic [DIR_ANCHO-1:0]    ptr_reg;
  logic [DIR_ANCHO-1:0]    ptr_actual;
  logic                    carga_acepta;

  // On the rising edge of Carga_activa the base is used directly, so a
  // byte offered in that same cycle lands at Carga_base.
  assign ptr_actual   = (Carga_activa && !activa_prev_reg) ? Carga_base : ptr_reg;
  assign Carga_listo  = Carga_activa && (estado_reg == REPOSO);
  assign carga_acepta = Carga_listo && Carga_valido;

  // While loading, CPU requests are ignored and every load byte is a write.
  assign aceptar      = (estado_reg == REPOSO) && (Carga_activa ? Carga_valido : Pet);
  assign es_escritura = Carga_activa ? 1'b1 : Escribir;
  assign dir_in       = Carga_activa ? ptr_actual : Pet_dir;
  assign dato_in      = Carga_activa ? Carga_dato : Pet_dato;

  // Load pointer: latched on activation, advanced (wrapping) per accepted byte.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      activa_prev_reg <= 1'b0;
      ptr_reg         <= '0;
    end else begin
      activa_prev_reg <= Carga_activa;
      if (carga_acepta) begin
        ptr_reg <= ptr_actual + 1'b1;
      end else if (Carga_activa && !activa_prev_reg) begin
        ptr_reg <= Carga_base;
      end
    end
  end
`else
  assign aceptar      = (estado_reg == REPOSO) && Pet;
  assign es_escritura = Escribir;
  assign dir_in       = Pet_dir;
  assign dato_in      = Pet_dato;
`endif

  contador_espera #(
    .ANCHO (8)
  ) u_espera (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .cargar      (cnt_cargar),
    .valor       (cnt_valor),
    .decrementar (cnt_dec),
    .cero        (cnt_cero)
  );

  // State register; reset returns to REPOSO immediately, releasing the bus.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      estado_reg <= REPOSO;
    end else begin
      estado_reg <= estado_next;
    end
  end

  // Next-state logic for the read and write bus sequences.
  always_comb begin
    estado_next = estado_reg;
    case (estado_reg)
      REPOSO:     if (aceptar) estado_next = es_escritura ? ESCR_PREP : LECT;
      LECT:       if (cnt_cero) estado_next = REPOSO;
      ESCR_PREP:  estado_next = ESCR_PULSO;
      ESCR_PULSO: if (cnt_cero) estado_next = ESCR_FIN;
      ESCR_FIN:   estado_next = REPOSO;
      default:    estado_next = REPOSO;
    endcase
  end

  // Output decode: bus strobes, busy flag and wait-counter control.
  always_comb begin
    cnt_cargar = 1'b0;
    cnt_dec    = 1'b0;
    cnt_valor  = CUENTA_LECT;
    datos_oe   = (estado_reg == ESCR_PULSO);
    LE         = datos_oe ? LE_ESCRIBIR : LE_LEER;
    Ocupado    = (estado_reg != REPOSO);
    case (estado_reg)
      REPOSO: begin
        if (aceptar && !es_escritura) begin
          cnt_cargar = 1'b1;
          cnt_valor  = CUENTA_LECT;
        end
      end
      ESCR_PREP: begin
        cnt_cargar = 1'b1;
        cnt_valor  = CUENTA_ESCR;
      end
      LECT, ESCR_PULSO: cnt_dec = 1'b1;
      default: ;
    endcase
  end

  // Datapath: request capture, read-data capture and the Listo pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dir_reg   <= '0;
      dato_reg  <= '0;
      leido_reg <= '0;
      listo_reg <= 1'b0;
    end else begin
      listo_reg <= cnt_cero && ((estado_reg == LECT) || (estado_reg == ESCR_PULSO));
      if (aceptar) begin
        dir_reg  <= dir_in;
        dato_reg <= dato_in;
      end
      if ((estado_reg == LECT) && cnt_cero) begin
        leido_reg <= Datos;
      end
    end
  end

  assign Datos      = datos_oe ? dato_reg : {DATO_ANCHO{1'bz}};
  assign Direccion  = dir_reg;
  assign Dato_leido = leido_reg;
  assign Listo      = listo_reg;

endmodule
